// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Brief    : ID -> ID/EX bundle: decoded operands and control in, registered
//            *_IDEX view, stall and event counters out.
// Revision : 1.0
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_IFID, rs2_IFID, rd_IFID;
    logic             uses_rs1_ID, uses_rs2_ID;
    logic             RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID;
    logic [3:0]       ALUCtrl_ID;
    logic [XLEN-1:0]  pc_ID, rs1_data_ID, rs2_data_ID, imm_ID;
    logic             flush_EX;

    logic             stall;
    logic             valid_IDEX;
    logic [4:0]       rs1_IDEX, rs2_IDEX, rd_IDEX;
    logic             RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX;
    logic [3:0]       ALUCtrl_IDEX;
    logic [XLEN-1:0]  pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
    logic [CNT_W-1:0] stall_count, flush_count;

    modport master (
        output rs1_IFID, rs2_IFID, rd_IFID, uses_rs1_ID, uses_rs2_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID,
               ALUCtrl_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID, flush_EX,
        input  stall, valid_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX,
               RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX,
               ALUCtrl_IDEX, pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX,
               stall_count, flush_count
    );

    modport slave (
        input  rs1_IFID, rs2_IFID, rd_IFID, uses_rs1_ID, uses_rs2_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID,
               ALUCtrl_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID, flush_EX,
        output stall, valid_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX,
               RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX,
               ALUCtrl_IDEX, pc_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX,
               stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall, branch squash and
//            saturating stall/flush event counters.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q, valid_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic             regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic             memtoreg_q, memtoreg_d, alusrc_q, alusrc_d, branch_q, branch_d;
    logic [3:0]       aluctrl_q, aluctrl_d;
    logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
    logic             haz, stall_c;

    always_comb begin
        // Only a live load with a non-x0 destination can block the consumer in ID
        haz = valid_q & memread_q & (rd_q != 5'd0) &
              ((bus.uses_rs1_ID & (rd_q == bus.rs1_IFID)) |
               (bus.uses_rs2_ID & (rd_q == bus.rs2_IFID)));
        stall_c = haz & ~bus.flush_EX;

        valid_d       = valid_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        regwrite_d    = regwrite_q;
        memread_d     = memread_q;
        memwrite_d    = memwrite_q;
        memtoreg_d    = memtoreg_q;
        alusrc_d      = alusrc_q;
        branch_d      = branch_q;
        aluctrl_d     = aluctrl_q;
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (bus.flush_EX || stall_c) begin
            // Bubble: datapath values are left as-is, only qualifiers are cleared
            valid_d    = 1'b0;
            rs1_d      = 5'd0;
            rs2_d      = 5'd0;
            rd_d       = 5'd0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            alusrc_d   = 1'b0;
            branch_d   = 1'b0;
            aluctrl_d  = 4'd0;
        end else begin
            valid_d    = 1'b1;
            rs1_d      = bus.rs1_IFID;
            rs2_d      = bus.rs2_IFID;
            rd_d       = bus.rd_IFID;
            regwrite_d = bus.RegWrite_ID;
            memread_d  = bus.MemRead_ID;
            memwrite_d = bus.MemWrite_ID;
            memtoreg_d = bus.MemtoReg_ID;
            alusrc_d   = bus.ALUSrc_ID;
            branch_d   = bus.Branch_ID;
            aluctrl_d  = bus.ALUCtrl_ID;
            pc_d       = bus.pc_ID;
            rs1_data_d = bus.rs1_data_ID;
            rs2_data_d = bus.rs2_data_ID;
            imm_d      = bus.imm_ID;
        end

        if (bus.flush_EX) begin
            if (flush_count_q != CNT_MAX) flush_count_d = flush_count_q + 1'b1;
        end else if (stall_c) begin
            if (stall_count_q != CNT_MAX) stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
            regwrite_q    <= 1'b0;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            memtoreg_q    <= 1'b0;
            alusrc_q      <= 1'b0;
            branch_q      <= 1'b0;
            aluctrl_q     <= 4'd0;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            regwrite_q    <= regwrite_d;
            memread_q     <= memread_d;
            memwrite_q    <= memwrite_d;
            memtoreg_q    <= memtoreg_d;
            alusrc_q      <= alusrc_d;
            branch_q      <= branch_d;
            aluctrl_q     <= aluctrl_d;
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.valid_IDEX    = valid_q;
    assign bus.rs1_IDEX      = rs1_q;
    assign bus.rs2_IDEX      = rs2_q;
    assign bus.rd_IDEX       = rd_q;
    assign bus.RegWrite_IDEX = regwrite_q;
    assign bus.MemRead_IDEX  = memread_q;
    assign bus.MemWrite_IDEX = memwrite_q;
    assign bus.MemtoReg_IDEX = memtoreg_q;
    assign bus.ALUSrc_IDEX   = alusrc_q;
    assign bus.Branch_IDEX   = branch_q;
    assign bus.ALUCtrl_IDEX  = aluctrl_q;
    assign bus.pc_IDEX       = pc_q;
    assign bus.rs1_data_IDEX = rs1_data_q;
    assign bus.rs2_data_IDEX = rs2_data_q;
    assign bus.imm_IDEX      = imm_q;
    assign bus.stall_count   = stall_count_q;
    assign bus.flush_count   = flush_count_q;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed + randomized bench for id_ex_stage (CNT_W=16 and CNT_W=2
//            instances on shared stimulus) against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus shared by both instances; ctrl = {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch}
    logic [4:0]      s_rs1, s_rs2, s_rd;
    logic            s_u1, s_u2, s_flush;
    logic [5:0]      s_ctrl;
    logic [3:0]      s_alu;
    logic [XLEN-1:0] s_pc, s_d1, s_d2, s_imm;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(16)) if16 ();
    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(2))  if2 ();

    assign if16.rs1_IFID = s_rs1;       assign if2.rs1_IFID = s_rs1;
    assign if16.rs2_IFID = s_rs2;       assign if2.rs2_IFID = s_rs2;
    assign if16.rd_IFID = s_rd;         assign if2.rd_IFID = s_rd;
    assign if16.uses_rs1_ID = s_u1;     assign if2.uses_rs1_ID = s_u1;
    assign if16.uses_rs2_ID = s_u2;     assign if2.uses_rs2_ID = s_u2;
    assign if16.RegWrite_ID = s_ctrl[5]; assign if2.RegWrite_ID = s_ctrl[5];
    assign if16.MemRead_ID = s_ctrl[4];  assign if2.MemRead_ID = s_ctrl[4];
    assign if16.MemWrite_ID = s_ctrl[3]; assign if2.MemWrite_ID = s_ctrl[3];
    assign if16.MemtoReg_ID = s_ctrl[2]; assign if2.MemtoReg_ID = s_ctrl[2];
    assign if16.ALUSrc_ID = s_ctrl[1];   assign if2.ALUSrc_ID = s_ctrl[1];
    assign if16.Branch_ID = s_ctrl[0];   assign if2.Branch_ID = s_ctrl[0];
    assign if16.ALUCtrl_ID = s_alu;     assign if2.ALUCtrl_ID = s_alu;
    assign if16.pc_ID = s_pc;           assign if2.pc_ID = s_pc;
    assign if16.rs1_data_ID = s_d1;     assign if2.rs1_data_ID = s_d1;
    assign if16.rs2_data_ID = s_d2;     assign if2.rs2_data_ID = s_d2;
    assign if16.imm_ID = s_imm;         assign if2.imm_ID = s_imm;
    assign if16.flush_EX = s_flush;     assign if2.flush_EX = s_flush;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    id_ex_stage #(.XLEN(XLEN), .CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));

    int total = 0;
    int bad   = 0;

    // Behavioural model of the ID/EX slot; counters are unbounded and clipped on compare
    bit              m_known = 0;
    logic            m_valid;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [5:0]      m_ctrl;
    logic [3:0]      m_alu;
    logic [XLEN-1:0] m_pc, m_d1, m_d2, m_imm;
    int              m_stalls, m_flushes;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic model_haz();
        return m_valid && m_ctrl[4] && (m_rd != 5'd0) &&
               ((s_u1 && m_rd == s_rs1) || (s_u2 && m_rd == s_rs2));
    endfunction

    function automatic logic model_stall();
        return model_haz() && !s_flush;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic h;
        h = model_haz();
        if (!rst_n) begin
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_alu = 0;
            m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_stalls = 0; m_flushes = 0;
            m_known = 1;
        end else if (s_flush || h) begin
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_alu = 0;
            if (s_flush) m_flushes++;
            else         m_stalls++;
        end else begin
            m_valid = 1; m_rs1 = s_rs1; m_rs2 = s_rs2; m_rd = s_rd; m_ctrl = s_ctrl;
            m_alu = s_alu; m_pc = s_pc; m_d1 = s_d1; m_d2 = s_d2; m_imm = s_imm;
        end
    endtask

    task automatic check_regs();
        chk("valid", if16.valid_IDEX, m_valid);
        chk("rs1", if16.rs1_IDEX, m_rs1);
        chk("rs2", if16.rs2_IDEX, m_rs2);
        chk("rd", if16.rd_IDEX, m_rd);
        chk("ctrl", {if16.RegWrite_IDEX, if16.MemRead_IDEX, if16.MemWrite_IDEX,
                     if16.MemtoReg_IDEX, if16.ALUSrc_IDEX, if16.Branch_IDEX}, m_ctrl);
        chk("aluctrl", if16.ALUCtrl_IDEX, m_alu);
        chk("pc", if16.pc_IDEX, m_pc);
        chk("rs1_data", if16.rs1_data_IDEX, m_d1);
        chk("rs2_data", if16.rs2_data_IDEX, m_d2);
        chk("imm", if16.imm_IDEX, m_imm);
        chk("stall_count", if16.stall_count, sat(m_stalls, 65535));
        chk("flush_count", if16.flush_count, sat(m_flushes, 65535));
        chk("valid_w2", if2.valid_IDEX, m_valid);
        chk("stall_count_w2", if2.stall_count, sat(m_stalls, 3));
        chk("flush_count_w2", if2.flush_count, sat(m_flushes, 3));
    endtask

    // One clock: stall checked before the edge, registers checked #1 after it
    task automatic cycle();
        #1;
        if (m_known) begin
            chk("stall", if16.stall, model_stall());
            chk("stall_w2", if2.stall, model_stall());
        end
        @(posedge clk);
        model_edge();
        #1;
        if (m_known) check_regs();
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [5:0] ctrl,
                         input logic [XLEN-1:0] pc, input logic flush);
        s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_u1 = u1; s_u2 = u2; s_ctrl = ctrl;
        s_alu = 4'($urandom); s_pc = pc; s_d1 = $urandom; s_d2 = $urandom; s_imm = $urandom;
        s_flush = flush;
    endtask

    localparam logic [5:0] C_ADD = 6'b100000;
    localparam logic [5:0] C_LW  = 6'b110110;

    initial begin
        rst_n = 1'b0;
        drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 6'($urandom), $urandom, 1'b1);
        @(negedge clk);
        cycle();
        drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 6'($urandom), $urandom, 1'b0);
        cycle();
        chk("reset_valid", if16.valid_IDEX, 1'b0);
        chk("reset_pc", if16.pc_IDEX, 32'd0);
        chk("reset_stall_count", if16.stall_count, 16'd0);
        chk("reset_flush_count", if16.flush_count, 16'd0);
        chk("reset_stall", if16.stall, 1'b0);

        rst_n = 1'b1;
        drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD, 32'h100, 1'b0);
        cycle();
        chk("pass_rd", if16.rd_IDEX, 5'd3);
        chk("pass_regwrite", if16.RegWrite_IDEX, 1'b1);
        chk("pass_pc", if16.pc_IDEX, 32'h100);
        chk("pass_valid", if16.valid_IDEX, 1'b1);
        chk("pass_stall", if16.stall, 1'b0);

        // Load-use on rs1
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h104, 1'b0);
        cycle();
        drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, C_ADD, 32'h108, 1'b0);
        #1 chk("lu_stall", if16.stall, 1'b1);
        cycle();
        chk("lu_bubble_valid", if16.valid_IDEX, 1'b0);
        chk("lu_bubble_rs1", if16.rs1_IDEX, 5'd0);
        chk("lu_bubble_pc_held", if16.pc_IDEX, 32'h104);
        chk("lu_stall_count", if16.stall_count, 16'd1);
        chk("lu_stall_after", if16.stall, 1'b0);
        cycle();
        chk("lu_captured_valid", if16.valid_IDEX, 1'b1);
        chk("lu_captured_rs1", if16.rs1_IDEX, 5'd5);
        chk("lu_captured_pc", if16.pc_IDEX, 32'h108);

        // No false stall: lui x5 after lw x5, then lw x0 followed by a reader of x0
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h10c, 1'b0);
        cycle();
        drive(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_ADD, 32'h110, 1'b0);
        #1 chk("lui_no_stall", if16.stall, 1'b0);
        cycle();
        drive(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 32'h114, 1'b0);
        cycle();
        drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, C_ADD, 32'h118, 1'b0);
        #1 chk("x0_no_stall", if16.stall, 1'b0);
        cycle();

        // Flush wins over a simultaneous load-use
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h11c, 1'b0);
        cycle();
        drive(5'd5, 5'd0, 5'd9, 1'b1, 1'b0, C_ADD, 32'h120, 1'b1);
        #1 chk("flush_no_stall", if16.stall, 1'b0);
        cycle();
        chk("flush_valid", if16.valid_IDEX, 1'b0);
        chk("flush_count", if16.flush_count, 16'd1);
        chk("flush_stall_count", if16.stall_count, 16'd1);

        // Five more load-use stalls: 2-bit counter pins at 3
        for (int i = 0; i < 5; i++) begin
            drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 32'h200 + 32'(i * 8), 1'b0);
            cycle();
            drive(5'd0, 5'd5, 5'd9, 1'b0, 1'b1, C_ADD, 32'h204 + 32'(i * 8), 1'b0);
            cycle();
        end
        chk("sat_w2_stall_count", if2.stall_count, 2'd3);
        chk("sat_w16_stall_count", if16.stall_count, 16'd6);
        chk("sat_w2_flush_count", if2.flush_count, 2'd1);

        // Randomized traffic, biased toward register collisions with the slot
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            drive(($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom),
                  {1'($urandom), ($urandom_range(0, 9) < 5), 4'($urandom)},
                  $urandom,
                  ($urandom_range(0, 9) == 0));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
